play_music: RTL and testbench
=============================

# play_music

Playback decoder for recorded songs. Walks a song memory of 5-bit music codes (0 = rest, 1..21 = lo/mi/hi octave × 7 notes, 31 = end marker) at a fixed beat rate. Converts each code back to a one-hot note and an octave, and drives the same note/octave bus that the live keyboard path feeds into the tone generator. Sits between the song RAM and the buzzer/tone block.

## Interface
- BEAT_CYCLES, 25_000_000: clock cycles per song entry (sound + gap).
- GAP_CYCLES, 2_500_000: silent cycles at the end of each entry, so repeated notes separate; 1 ≤ GAP_CYCLES < BEAT_CYCLES.
- DEPTH, 64: number of entries in the song memory.
- ADDR_W, 6: width of the memory address; 2^ADDR_W ≥ DEPTH.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to play from address 0; ignored unless idle.
- stop  in  1  abort playback; takes priority over start.
- mem_rd  out  1  read strobe to the song memory.
- mem_addr  out  ADDR_W  read address.
- mem_data  in  5  music code; valid the cycle after mem_rd.
- note  out  8  one-hot note, bit0 = first scale note, bit6 = seventh, bit7 always 0; all-zero = silent.
- octave  out  2  shared octave constants lo / mi / hi.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on natural end of song.

## Operation
- States: IDLE, FETCH, WAIT, HOLD, GAP, FINISH.
- IDLE: note=0, mem_rd=0. start=1 and stop=0 → FETCH with addr=0.
- FETCH: one cycle, mem_rd=1, mem_addr=addr → WAIT.
- WAIT: one cycle, sample mem_data:
  - 31 → FINISH.
  - 0 → note=0, octave unchanged → HOLD.
  - 1..7 → octave=lo, note=1<<(code-1) → HOLD.
  - 8..14 → octave=mi, note=1<<(code-8) → HOLD.
  - 15..21 → octave=hi, note=1<<(code-15) → HOLD.
  - 22..30 → treated as rest (note=0) → HOLD.
- HOLD: BEAT_CYCLES-GAP_CYCLES cycles, outputs held → GAP.
- GAP: GAP_CYCLES cycles, note=0, octave held. At the end:
  - addr==DEPTH-1 → FINISH.
  - else addr+1 → FETCH.
- FINISH: one cycle, done=1, note=0, addr=0 → IDLE.
- stop=1 in any non-IDLE state → IDLE next cycle; note=0, addr=0, no done pulse.
- start while busy: ignored. start and stop in the same cycle: stop wins.
- A single down-counter of width ⌈log2 BEAT_CYCLES⌉ is shared by HOLD and GAP. It is reloaded on each state entry, and the transition happens when it reaches 1.
- Address counter does not wrap: DEPTH-1 ends the song.

## Timing
- All outputs are registered.
- Reset values: note=0, octave=mi, mem_rd=0, mem_addr=0, busy=0, done=0, state=IDLE, counters=0.
- start sampled at cycle 0:
  - cycle 1: FETCH, mem_rd=1, addr=0.
  - cycle 2: WAIT, data captured.
  - cycle 3: first cycle with the decoded note visible.
- Each entry occupies exactly BEAT_CYCLES+2 cycles:
  - 2 cycles fetch/decode with note=0.
  - BEAT_CYCLES-GAP_CYCLES cycles sounding.
  - GAP_CYCLES cycles silent.
- End marker: done asserts 2 cycles after its FETCH. Full song: done asserts the cycle after the last GAP cycle.
- busy rises the cycle after start and falls the cycle after done or stop.
- rst mid-song overrides everything and returns all outputs to reset values on the next edge.

## Test plan
Parameters for all scenarios: BEAT_CYCLES=4, GAP_CYCLES=1, DEPTH=8.

- Reset then idle: rst 2 cycles, no start → note=0, octave=mi, busy=0, mem_rd=0 for 20 cycles.
- Decode sweep: memory codes 1,8,15,7,14,21,0,31; pulse start → in turn note=01h lo, 01h mi, 01h hi, 40h lo, 40h mi, 40h hi, then 00h with octave hi held. Each note lasts 3 cycles with 1 silent gap cycle, spaced 6 cycles apart. done pulses at the 31 entry.
- Full depth: memory 8×code 10 → eight 3-cycle bursts of note=04h, octave=mi; mem_addr 0..7 with no wrap; done exactly once, 48 cycles after start+1; busy then drops.
- Stop mid-note: stop during the second HOLD → next cycle note=0, busy=0, no done. A following start replays from mem_addr=0.
- Priority and ignore: start+stop in the same cycle while IDLE → stays IDLE. start pulsed during HOLD → playback timing unchanged.
- Invalid codes and reset: code 25 → note=0 for the whole entry. rst asserted in GAP → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/play_music.sv
// play_music: steps through song memory at a fixed beat rate, decoding each code into a one-hot note and an octave.
module play_music #(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [4:0]        mem_data,
  output logic [7:0]        note,
  output logic [1:0]        octave,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(BEAT_CYCLES);
  localparam logic [CW-1:0] HOLD_LEN = CW'(BEAT_CYCLES - GAP_CYCLES);
  localparam logic [CW-1:0] GAP_LEN = CW'(GAP_CYCLES);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [1:0] OCT_LO = 2'd0, OCT_MI = 2'd1, OCT_HI = 2'd2;
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, WAIT = 3'd2, HOLD = 3'd3, GAP = 3'd4, FINISH = 3'd5;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic lo, mi, hi;
  logic [4:0] idx;
  logic [7:0] dec_note;
  logic [1:0] dec_oct;
  assign lo = mem_data >= 5'd1 && mem_data <= 5'd7;
  assign mi = mem_data >= 5'd8 && mem_data <= 5'd14;
  assign hi = mem_data >= 5'd15 && mem_data <= 5'd21;
  assign idx = lo ? mem_data - 5'd1 : mi ? mem_data - 5'd8 : mem_data - 5'd15;
  // rests and unused codes 22..30 fall through to silence with the octave kept
  assign dec_note = (lo | mi | hi) ? 8'd1 << idx[2:0] : 8'd0;
  assign dec_oct = lo ? OCT_LO : mi ? OCT_MI : hi ? OCT_HI : octave;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      note <= '0;
      octave <= OCT_MI;
      mem_rd <= 1'b0;
      mem_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      done <= 1'b0;
      if (stop && state != IDLE) begin
        state <= IDLE;
        note <= '0;
        mem_addr <= '0;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start && !stop) begin
            state <= FETCH;
            mem_rd <= 1'b1;
            mem_addr <= '0;
            busy <= 1'b1;
          end
          FETCH: state <= WAIT;
          WAIT: if (mem_data == 5'd31) begin
            state <= FINISH;
            done <= 1'b1;
            mem_addr <= '0;
          end else begin
            state <= HOLD;
            note <= dec_note;
            octave <= dec_oct;
            cnt <= HOLD_LEN;
          end
          HOLD: if (cnt == CW'(1)) begin
            state <= GAP;
            note <= '0;
            cnt <= GAP_LEN;
          end else cnt <= cnt - CW'(1);
          GAP: if (cnt != CW'(1)) cnt <= cnt - CW'(1);
          else if (mem_addr == LAST) begin
            state <= FINISH;
            done <= 1'b1;
            mem_addr <= '0;
          end else begin
            state <= FETCH;
            mem_rd <= 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
          FINISH: begin
            state <= IDLE;
            busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_play_music.sv
// tb_play_music: decode table plus scoreboarded per-cycle timelines for play_music.
module tb_play_music;
  localparam logic [1:0] LO = 2'd0, MI = 2'd1, HI = 2'd2;
  typedef struct packed {
    logic [7:0] note;
    logic [1:0] oct;
    logic       busy;
    logic       rd;
    logic [2:0] addr;
    logic       done;
  } snap_t;
  typedef struct {
    logic [4:0] code;
    logic [7:0] note;
    logic [1:0] oct;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, stop = 0;
  logic mem_rd, busy, done;
  logic [2:0] mem_addr;
  logic [4:0] mem_data = '0;
  logic [7:0] note;
  logic [1:0] octave;
  logic [4:0] mem [8];
  logic [7:0] en [8];
  logic [1:0] eo [8];
  logic [1:0] moct;
  snap_t q[$];
  vec_t tbl [7];
  int tests = 0, fails = 0;
  play_music #(.BEAT_CYCLES(4), .GAP_CYCLES(1), .DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .note(note), .octave(octave), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];
  function automatic snap_t mk(input logic [7:0] n, input logic [1:0] o, input logic b, input logic r, input int a, input logic d);
    mk = '{note: n, oct: o, busy: b, rd: r, addr: 3'(a), done: d};
  endfunction
  function automatic snap_t idle_snap(input logic [1:0] o);
    idle_snap = mk(8'h00, o, 1'b0, 1'b0, 0, 1'b0);
  endfunction
  task automatic gen(input int n);
    for (int a = 0; a < n; a++) begin
      q.push_back(mk(8'h00, moct, 1'b1, 1'b1, a, 1'b0));
      q.push_back(mk(8'h00, moct, 1'b1, 1'b0, a, 1'b0));
      if (mem[a] == 5'd31) begin
        q.push_back(mk(8'h00, moct, 1'b1, 1'b0, 0, 1'b1));
        q.push_back(idle_snap(moct));
        return;
      end
      moct = eo[a];
      repeat (3) q.push_back(mk(en[a], moct, 1'b1, 1'b0, a, 1'b0));
      q.push_back(mk(8'h00, moct, 1'b1, 1'b0, a, 1'b0));
    end
    q.push_back(mk(8'h00, moct, 1'b1, 1'b0, 0, 1'b1));
    q.push_back(idle_snap(moct));
  endtask
  task automatic run(input string name, input bit st, input bit sp, input int stop_at, input int poke_at, input int rst_at);
    snap_t e, g;
    int k = 0;
    start = st;
    stop = sp;
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      start = 0;
      stop = 0;
      rst = 0;
      e = q.pop_front();
      g = {note, octave, busy, mem_rd, mem_addr, done};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL %s cyc%0d got note=%h oct=%0d busy=%b rd=%b addr=%0d done=%b, want note=%h oct=%0d busy=%b rd=%b addr=%0d done=%b",
          name, k + 1, g.note, g.oct, g.busy, g.rd, g.addr, g.done, e.note, e.oct, e.busy, e.rd, e.addr, e.done);
      end
      if (k == stop_at) stop = 1;
      if (k == poke_at) start = 1;
      if (k == rst_at) rst = 1;
      k++;
    end
  endtask
  initial begin
    tbl[0] = '{5'd1, 8'h01, LO};
    tbl[1] = '{5'd8, 8'h01, MI};
    tbl[2] = '{5'd15, 8'h01, HI};
    tbl[3] = '{5'd7, 8'h40, LO};
    tbl[4] = '{5'd14, 8'h40, MI};
    tbl[5] = '{5'd21, 8'h40, HI};
    tbl[6] = '{5'd0, 8'h00, HI};
    repeat (2) @(posedge clk);
    #1;
    moct = MI;
    repeat (20) q.push_back(idle_snap(MI));
    run("reset_idle", 0, 0, -1, -1, -1);
    for (int i = 0; i < 7; i++) begin
      mem[i] = tbl[i].code;
      en[i] = tbl[i].note;
      eo[i] = tbl[i].oct;
    end
    mem[7] = 5'd31;
    gen(8);
    run("sweep", 1, 0, -1, -1, -1);
    for (int i = 0; i < 8; i++) begin
      mem[i] = 5'd10;
      en[i] = 8'h04;
      eo[i] = MI;
    end
    gen(8);
    run("full_depth", 1, 0, -1, -1, -1);
    gen(8);
    q = q[0:8];
    repeat (4) q.push_back(idle_snap(MI));
    run("stop_mid", 1, 0, 8, -1, -1);
    gen(8);
    run("replay_poke", 1, 0, -1, 3, -1);
    repeat (4) q.push_back(idle_snap(MI));
    run("start_stop", 1, 1, -1, -1, -1);
    mem[0] = 5'd18;
    mem[1] = 5'd25;
    mem[2] = 5'd31;
    en[0] = 8'h08;
    eo[0] = HI;
    en[1] = 8'h00;
    eo[1] = HI;
    gen(3);
    q = q[0:11];
    repeat (3) q.push_back(idle_snap(MI));
    run("invalid_rst", 1, 0, -1, -1, 11);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
